// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer
// Parallel-to-serial front end for the bit-stream pattern detectors.
// Words arrive over a valid/ready handshake and leave one bit per bit_en
// strobe on out_bit. A shift register holds the word in flight, and a
// one-word holding register lets the next word follow with no idle bit.

module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             bit_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Move the word one position toward the output end; the vacated
    // position fills with zero.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {w[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, w[WIDTH-1:1]};
        end
        return r;
    endfunction

    // The bit currently sitting at the output end of the shift register.
    function automatic logic out_end(input logic [WIDTH-1:0] w);
        logic r;
        if (MSB_FIRST) begin
            r = w[WIDTH-1];
        end else begin
            r = w[0];
        end
        return r;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hr_q, hr_d;
    logic             hr_full_q, hr_full_d;

    logic             accept;
    logic             shifting;
    logic             last_bit;

    // The block can take a word whenever the holding register is free.
    assign s_ready  = !hr_full_q;
    assign accept   = s_valid && s_ready;
    assign shifting = (state_q == ST_SHIFT);
    // The final bit of the word in flight is consumed at this edge.
    assign last_bit = shifting && bit_en && (cnt_q == CNT_LAST);

    // Next-state logic for the FSM, the shift register, the counter and the
    // holding register.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        hr_d      = hr_q;
        hr_full_d = hr_full_q;

        case (state_q)
            ST_IDLE: begin
                // bit_en has no meaning without a word in flight.
                if (accept) begin
                    sr_d    = s_data;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bit_en) begin
                    if (cnt_q != CNT_LAST) begin
                        sr_d  = advance(sr_q);
                        cnt_d = cnt_q + 1'b1;
                    end else if (hr_full_q) begin
                        // The parked word follows immediately.
                        sr_d      = hr_q;
                        cnt_d     = CNT_ZERO;
                        hr_full_d = 1'b0;
                    end else if (accept) begin
                        // A word arriving exactly as the last bit leaves skips
                        // the holding register, so there is no bubble.
                        sr_d  = s_data;
                        cnt_d = CNT_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                // Any other accept while a word is in flight is parked. When
                // the last bit leaves with HR full, s_ready is low, so this
                // cannot overwrite a word being moved into SR.
                if (accept && !last_bit) begin
                    hr_d      = s_data;
                    hr_full_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                hr_full_d = 1'b0;
            end
        endcase
    end

    // Control state and the shift register, cleared asynchronously so a reset
    // mid-word drops out_valid at once and discards both words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= CNT_ZERO;
            hr_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            hr_full_q <= hr_full_d;
        end
    end

    // Holding-register data; its contents matter only while hr_full_q is set.
    always_ff @(posedge clk) begin
        hr_q <= hr_d;
    end

    // Outputs are decoded from registers only, with no path from any input.
    assign out_valid  = shifting;
    assign out_bit    = shifting ? out_end(sr_q) : IDLE_BIT;
    assign word_start = shifting && (cnt_q == CNT_ZERO);
    assign busy       = shifting || hr_full_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench for bit_stream_serializer: two instances (MSB-first and
// LSB-first) share the same stimulus and are compared every cycle against a
// word-queue reference model, plus a vector table and directed sequences.

module tb_bit_stream_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       bit_en;

    logic msb_rdy, msb_bit, msb_vld, msb_ws, msb_busy;
    logic lsb_rdy, lsb_bit, lsb_vld, lsb_ws, lsb_busy;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(msb_rdy), .bit_en(bit_en), .out_bit(msb_bit),
        .out_valid(msb_vld), .word_start(msb_ws), .busy(msb_busy)
    );

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(lsb_rdy), .bit_en(bit_en), .out_bit(lsb_bit),
        .out_valid(lsb_vld), .word_start(lsb_ws), .busy(lsb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, int'(act), int'(exp));
    endtask

    // Reference model: a queue of accepted words not yet fully sent, plus the
    // index of the bit currently on the wire in the head word. Capacity is two
    // words: the one in flight and one waiting.
    logic [7:0] mq[$];
    int         mpos = 0;

    always @(posedge clk or posedge reset) begin
        bit acc;
        if (reset) begin
            mq.delete();
            mpos = 0;
        end else begin
            acc = s_valid && (mq.size() < 2);
            if (mq.size() > 0 && bit_en) begin
                mpos++;
                if (mpos == 8) begin
                    void'(mq.pop_front());
                    mpos = 0;
                end
            end
            if (acc) mq.push_back(s_data);
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [7:0] w;
        logic       mv;
        if (chk_en) begin
            mv = (mq.size() > 0);
            w  = mv ? mq[0] : 8'h00;
            chk1("model msb out_valid", msb_vld, mv);
            chk1("model lsb out_valid", lsb_vld, mv);
            chk1("model msb out_bit", msb_bit, mv ? w[7-mpos] : 1'b0);
            chk1("model lsb out_bit", lsb_bit, mv ? w[mpos] : 1'b0);
            chk1("model msb word_start", msb_ws, mv && (mpos == 0));
            chk1("model lsb word_start", lsb_ws, mv && (mpos == 0));
            chk1("model msb s_ready", msb_rdy, mq.size() < 2);
            chk1("model lsb s_ready", lsb_rdy, mq.size() < 2);
            chk1("model msb busy", msb_busy, mv);
            chk1("model lsb busy", lsb_busy, mv);
        end
    end

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       be;
        logic       e_msb;
        logic       e_lsb;
        logic       e_vld;
        logic       e_ws;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[10];

    task automatic set_row(input int i, input logic sv, input logic [7:0] sd,
                           input logic em, input logic el, input logic ev,
                           input logic ew);
        tbl[i].sv    = sv;
        tbl[i].sd    = sd;
        tbl[i].be    = 1'b1;
        tbl[i].e_msb = em;
        tbl[i].e_lsb = el;
        tbl[i].e_vld = ev;
        tbl[i].e_ws  = ew;
        tbl[i].e_rdy = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic run_table();
        // 8'hB4: MSB-first 1,0,1,1,0,1,0,0 ; LSB-first 0,0,1,0,1,1,0,1
        set_row(0, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 1'b1);
        set_row(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        set_row(2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        set_row(3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        set_row(4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        set_row(5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        set_row(6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        set_row(7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        set_row(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        set_row(9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            s_valid = tbl[i].sv;
            s_data  = tbl[i].sd;
            bit_en  = tbl[i].be;
            @(negedge clk);
            chk1($sformatf("tbl[%0d] msb out_bit", i), msb_bit, tbl[i].e_msb);
            chk1($sformatf("tbl[%0d] lsb out_bit", i), lsb_bit, tbl[i].e_lsb);
            chk1($sformatf("tbl[%0d] out_valid", i), msb_vld, tbl[i].e_vld);
            chk1($sformatf("tbl[%0d] word_start", i), msb_ws, tbl[i].e_ws);
            chk1($sformatf("tbl[%0d] s_ready", i), msb_rdy, tbl[i].e_rdy);
        end
    endtask

    task automatic run_b2b();
        logic [7:0] w[3];
        int idx = 0, nacc = 0, nvld = 0, first = -1, last = -1, nrdy0 = 0;
        int ws_pos[$];
        bit acc_prev;
        w[0] = 8'hFF; w[1] = 8'h00; w[2] = 8'hA5;
        @(negedge clk);
        bit_en  = 1'b1;
        s_valid = 1'b1;
        s_data  = w[0];
        for (int c = 0; c < 40; c++) begin
            acc_prev = s_valid && msb_rdy;
            @(negedge clk);
            if (acc_prev) begin
                nacc++;
                idx++;
                if (idx < 3) s_data = w[idx];
                else s_valid = 1'b0;
            end
            if (msb_vld) begin
                nvld++;
                if (first < 0) first = c;
                last = c;
            end
            if (msb_ws && first >= 0) ws_pos.push_back(c - first);
            if (!msb_rdy) nrdy0++;
        end
        chk("b2b accepts", nacc, 3);
        chk("b2b out_valid cycles", nvld, 24);
        chk("b2b contiguous span", last - first + 1, 24);
        chk("b2b word_start count", ws_pos.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("b2b word_start[%0d] offset", k),
                (ws_pos.size() > k) ? ws_pos[k] : -1, 8 * k);
        chk("b2b s_ready low cycles", nrdy0, 14);
    endtask

    task automatic run_pacing();
        logic [7:0] gm = 8'h00, gl = 8'h00;
        int nbits = 0, nvld = 0;
        bit acc_prev;
        @(negedge clk);
        s_valid  = 1'b1;
        s_data   = 8'hC3;
        bit_en   = 1'b0;
        acc_prev = s_valid && msb_rdy;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (acc_prev) s_valid = 1'b0;
            acc_prev = 1'b0;
            if (msb_vld) nvld++;
            bit_en = (c % 3 == 2);
            if (msb_vld && bit_en) begin
                gm = {gm[6:0], msb_bit};
                gl = {gl[6:0], lsb_bit};
                nbits++;
            end
        end
        bit_en = 1'b0;
        chk("pace bits consumed", nbits, 8);
        chk("pace msb sequence", int'(gm), 32'hC3);
        chk("pace lsb sequence", int'(gl), 32'hC3);
        chk1("pace out_valid time in 22..26", nvld >= 22 && nvld <= 26, 1'b1);
    endtask

    task automatic run_reset_mid();
        logic [7:0] gm = 8'h00, gl = 8'h00;
        int nv = 0;
        @(negedge clk);
        bit_en  = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hF0;
        @(negedge clk);
        s_data  = 8'h0F;
        @(negedge clk);
        s_valid = 1'b0;
        chk1("rst HR full before reset", msb_rdy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk1("rst async out_valid msb", msb_vld, 1'b0);
        chk1("rst async out_valid lsb", lsb_vld, 1'b0);
        chk1("rst async busy", msb_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk1("rst s_ready after release", msb_rdy, 1'b1);
        chk1("rst busy after release", msb_busy, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (msb_vld || lsb_vld) nv++;
        end
        chk("rst stale bits after release", nv, 0);
        s_valid = 1'b1;
        s_data  = 8'h81;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            s_valid = 1'b0;
            if (c == 0) chk1("rst 81 word_start", msb_ws, 1'b1);
            gm = {gm[6:0], msb_bit};
            gl = {gl[6:0], lsb_bit};
        end
        chk("rst 81 msb sequence", int'(gm), 32'h81);
        chk("rst 81 lsb sequence", int'(gl), 32'h81);
        @(negedge clk);
        chk1("rst 81 done", msb_vld, 1'b0);
    endtask

    task automatic run_idle();
        int bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bit_en = ~bit_en;
            if (msb_vld || lsb_vld || msb_bit || lsb_bit || msb_busy || msb_ws) bad++;
        end
        chk("idle bit_en disturbances", bad, 0);
        bit_en = 1'b0;
    endtask

    task automatic run_random();
        int rate;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rate    = (c / 300) % 4;
            s_valid = ($urandom_range(0, 3) < rate + 1);
            s_data  = 8'($urandom);
            bit_en  = (rate == 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 249) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
        end
        s_valid = 1'b0;
        bit_en  = 1'b1;
        repeat (20) @(negedge clk);
        chk1("random drained", msb_busy, 1'b0);
    endtask

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        bit_en  = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_en = 1'b1;
        chk1("reset out_valid", msb_vld, 1'b0);
        chk1("reset out_bit", msb_bit, 1'b0);
        chk1("reset word_start", msb_ws, 1'b0);
        chk1("reset busy", msb_busy, 1'b0);
        chk1("reset s_ready", msb_rdy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;

        run_table();
        run_b2b();
        pulse_reset();
        run_pacing();
        run_reset_mid();
        run_idle();
        run_random();

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
